mux_logic_unit: RTL and testbench
=================================

// Module: mux_logic_unit
// PURPOSE
//  Parametrised, pipelined bitwise logic unit. Every gate function is built per bit from 2:1 mux
//  primitives: AND = b?a:0, OR = b?1:a, NOT = a?0:1, and the other functions compose from these.
//  Operands and opcode enter on a valid/ready stream. The result leaves on a second valid/ready
//  stream after 2 pipeline stages. An accumulate mode chains results without software round-trips.
//  The unit sits between operand producers and result consumers in the logic-test datapath.
// PARAMETERS
//  WIDTH    8   operand/result width in bits (>=1)
//  COUNT_W  16  width of the completed-operation counter (>=1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        unit can accept input beat
//  in_a       in   WIDTH    operand a
//  in_b       in   WIDTH    operand b
//  in_op      in   3        0 AND,1 OR,2 NOT a,3 XOR,4 NAND,5 NOR,6 XNOR,7 PASS b
//  in_acc     in   1        1: replace operand a with acc_q at compute time
//  acc_clr    in   1        synchronous clear of accumulator (pulse, independent of handshake)
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_data   out  WIDTH    result
//  out_zero   out  1        out_data == 0
//  out_parity out  1        XOR-reduce of out_data
//  op_count   out  COUNT_W  number of output handshakes, saturating at all-ones
// BEHAVIOUR
//  - Reset (rst_n low, async): s1_valid=0, s2_valid=0, out_data=0, acc_q=0, op_count=0.
//    While reset is held, out_valid=0. out_zero=1 and out_parity=0, because they follow out_data.
//  - Stage 1 (S1) registers a, b, op and acc. Stage 2 (S2) registers the computed result.
//    Latency is 2 clocks from input handshake to out_valid when the pipe is unstalled.
//    Full throughput is 1 beat/clock.
//  - s2_ready = !s2_valid | out_ready.
//  - s1_ready = !s1_valid | s2_ready.
//  - in_ready = s1_ready. in_ready is combinational and is 1 out of reset.
//  - Input handshake happens when in_valid & in_ready; S1 loads on it.
//    S1 empties when it moves to S2 with no new input that cycle.
//  - S2 loads when s1_valid & s2_ready: out_data <= f(op, A, s1_b), with A = s1_acc ? acc_q : s1_a.
//    At the same edge, acc_q <= the new result.
//  - Back-to-back acc beats therefore chain correctly with no bubbles.
//  - acc_clr=1 forces acc_q <= 0 and takes priority over the result load in the same cycle.
//    out_data still shows the computed result.
//  - Stall: while out_valid & !out_ready, out_data, out_zero and out_parity stay stable.
//    S1 holds. in_ready=0 once S1 is also full.
//  - op_count increments on each out_valid & out_ready. At all-ones it holds (no wrap).
//  - Reset mid-operation drops all in-flight beats; no output is produced for them.
//  - All operations are bitwise and have no carries. The result width is exactly WIDTH.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream -> out_valid=0, out_data=0, op_count=0 immediately;
//    in_ready=1 after release.
//  2 Op sweep (WIDTH=8): a=8'hA5, b=8'h3C, op 0..7, out_ready=1 ->
//    results 24, BD, 5A, 99, DB, 42, 66, 3C, each 2 clocks after input.
//  3 Backpressure: stream 4 beats with out_ready=0 -> in_ready falls after 2 accepted beats.
//    Raising out_ready -> 4 results arrive in order, none lost or duplicated.
//  4 Accumulate: acc_clr pulse, then op=OR with in_acc=1 and b=01, 02, 04 back-to-back ->
//    outputs 01, 03, 07.
//  5 acc_clr coincident with the S2 load of 07 -> out_data=07, next acc OR b=10 -> 10.
//  6 Counter saturation (COUNT_W=2): 5 handshakes -> op_count = 1, 2, 3, 3, 3.
//    Flags: out_data=00 -> out_zero=1, parity=0. out_data=07 -> out_zero=0, parity=1.

Source files
------------

// File: rtl/mux_logic_unit.sv
// mux_logic_unit: two-stage pipelined bitwise logic unit. Every gate is built
// per bit from 2:1 multiplexers. Valid/ready on both sides, an accumulator
// for chaining results, and a saturating count of delivered results.
module mux_logic_unit #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         in_op,
    input  logic               in_acc,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               out_parity,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // Stage 1 holds the accepted operands; stage 2 is the output register.
    logic             s1_valid;
    logic             s1_acc;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic             s2_valid;

    logic             s1_ready;
    logic             s2_ready;
    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;

    // The single primitive everything is built from.
    function automatic logic mux2(input logic sel, input logic d1, input logic d0);
        return sel ? d1 : d0;
    endfunction

    function automatic logic g_and(input logic a, input logic b);
        return mux2(b, a, 1'b0);
    endfunction

    function automatic logic g_or(input logic a, input logic b);
        return mux2(b, 1'b1, a);
    endfunction

    function automatic logic g_not(input logic a);
        return mux2(a, 1'b0, 1'b1);
    endfunction

    // b selects between a and its inverse.
    function automatic logic g_xor(input logic a, input logic b);
        return mux2(b, g_not(a), a);
    endfunction

    // Each stage can take a beat if it is empty or its content leaves this cycle.
    assign s2_ready = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;
    assign s1_load  = in_valid && s1_ready;
    assign s2_load  = s1_valid && s2_ready;

    assign out_valid  = s2_valid;
    assign out_zero   = ~|out_data;
    assign out_parity = ^out_data;

    // Operand a is taken from the accumulator at compute time so chained beats see the latest result.
    assign op_a = s1_acc ? acc_q : s1_a;

    // Per-bit gate evaluation selected by the stage-1 opcode.
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves result unassigned (no latch).
        result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (s1_op)
                OP_AND:  result[i] = g_and(op_a[i], s1_b[i]);
                OP_OR:   result[i] = g_or(op_a[i], s1_b[i]);
                OP_NOT:  result[i] = g_not(op_a[i]);
                OP_XOR:  result[i] = g_xor(op_a[i], s1_b[i]);
                OP_NAND: result[i] = g_not(g_and(op_a[i], s1_b[i]));
                OP_NOR:  result[i] = g_not(g_or(op_a[i], s1_b[i]));
                OP_XNOR: result[i] = g_not(g_xor(op_a[i], s1_b[i]));
                OP_PASS: result[i] = s1_b[i];
                default: result[i] = 1'b0;
            endcase
        end
    end

    // Stage-1 occupancy: fills on input handshake, empties when it drains with nothing new behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage-1 payload; qualified by s1_valid so it needs no reset.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are deliberately left unreset; only the valid bits gate their use.
        if (s1_load) begin
            s1_a   <= in_a;
            s1_b   <= in_b;
            s1_op  <= op_e'(in_op);
            s1_acc <= in_acc;
        end
    end

    // Stage-2 output register: loads the computed result, clears when consumed with no follower.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            out_data <= result;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Accumulator tracks every result; a clear pulse wins over a same-cycle load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (s2_load) begin
            acc_q <= result;
        end
    end

    // Count delivered results, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_valid && out_ready && (op_count != '1)) begin
            op_count <= op_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mux_logic_unit.sv
// tb_mux_logic_unit: directed tests for mux_logic_unit. A second instance with a
// 2-bit counter shares the inputs and is used for the saturation test.
module tb_mux_logic_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       in_acc;
    logic       acc_clr;
    logic       out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_zero;
    logic        out_parity;
    logic [15:0] op_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [7:0]  s_out_data;
    logic        s_out_zero;
    logic        s_out_parity;
    logic [1:0]  s_op_count;

    int n_cmp = 0;
    int n_bad = 0;

    mux_logic_unit #(.WIDTH(8), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_parity(out_parity), .op_count(op_count)
    );

    mux_logic_unit #(.WIDTH(8), .COUNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_zero(s_out_zero), .out_parity(s_out_parity), .op_count(s_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_a     = 8'h00;
        in_b     = 8'h00;
        in_op    = 3'd0;
        in_acc   = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        in_op = 3'd7; in_b = 8'h5A; in_valid = 1'b1;
        step();
        in_b = 8'h77;
        step();
        in_valid = 1'b0;
        step();
        // One result delivered, one in S2: assert reset mid-stream.
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        n_cmp++; if (op_count !== 16'd0) begin n_bad++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
        n_cmp++; if (out_zero !== 1'b1 || out_parity !== 1'b0) begin n_bad++; $display("FAIL reset_flags got zero=%b par=%b exp zero=1 par=0", out_zero, out_parity); end
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dropped cyc=%0d got out_valid=%b exp=0", k, out_valid); end
        end
    endtask

    task automatic test_op_sweep();
        logic [7:0] exp_tab [8];
        exp_tab[0] = 8'h24; exp_tab[1] = 8'hBD; exp_tab[2] = 8'h5A; exp_tab[3] = 8'h99;
        exp_tab[4] = 8'hDB; exp_tab[5] = 8'h42; exp_tab[6] = 8'h66; exp_tab[7] = 8'h3C;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_a = 8'hA5; in_b = 8'h3C; in_op = 3'(i); in_acc = 1'b0; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sweep_early op=%0d got out_valid=%b exp=0", i, out_valid); end
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_tab[i]) begin n_bad++; $display("FAIL sweep op=%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_tab[i]); end
            n_cmp++; if (out_parity !== ^exp_tab[i]) begin n_bad++; $display("FAIL sweep_parity op=%0d got=%b exp=%b", i, out_parity, ^exp_tab[i]); end
        end
        step();
        n_cmp++; if (op_count !== 16'd8) begin n_bad++; $display("FAIL sweep_count got=%0d exp=8", op_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] bp [4];
        int sent, got;
        logic took_in;
        bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h33; bp[3] = 8'h44;
        sent = 0; got = 0;
        out_ready = 1'b0;
        in_op = 3'd7; in_acc = 1'b0; in_a = 8'h00;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (cyc == 6) out_ready = 1'b1;
            in_valid = (sent < 4);
            in_b = (sent < 4) ? bp[sent] : 8'h00;
            #1;
            took_in = in_valid && in_ready;
            if (cyc == 4) begin
                n_cmp++; if (sent != 2 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall_ready got sent=%0d in_ready=%b exp sent=2 in_ready=0", sent, in_ready); end
                n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin n_bad++; $display("FAIL bp_stall_hold got v=%b d=%h exp v=1 d=11", out_valid, out_data); end
            end
            if (out_valid && out_ready) begin
                n_cmp++; if (out_data !== bp[got]) begin n_bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", got, out_data, bp[got]); end
                got++;
            end
            step();
            if (took_in) sent++;
        end
        in_valid = 1'b0;
        n_cmp++; if (got != 4 || sent != 4) begin n_bad++; $display("FAIL bp_total got recv=%0d sent=%0d exp 4/4", got, sent); end
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_dup got out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_accumulate();
        out_ready = 1'b1;
        in_valid = 1'b0;
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        in_op = 3'd1; in_acc = 1'b1; in_a = 8'hFF;
        in_b = 8'h01; in_valid = 1'b1;
        step();
        in_b = 8'h02;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin n_bad++; $display("FAIL acc_1 got v=%b d=%h exp v=1 d=01", out_valid, out_data); end
        in_b = 8'h04;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin n_bad++; $display("FAIL acc_2 got v=%b d=%h exp v=1 d=03", out_valid, out_data); end
        // Clear lands on the same edge that loads 07 into S2.
        in_valid = 1'b0;
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h07) begin n_bad++; $display("FAIL acc_3 got v=%b d=%h exp v=1 d=07", out_valid, out_data); end
        n_cmp++; if (out_zero !== 1'b0 || out_parity !== 1'b1) begin n_bad++; $display("FAIL flags_07 got zero=%b par=%b exp zero=0 par=1", out_zero, out_parity); end
        in_b = 8'h10; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin n_bad++; $display("FAIL acc_clr_chain got v=%b d=%h exp v=1 d=10", out_valid, out_data); end
        in_acc = 1'b0;
        step();
    endtask

    task automatic test_counter_sat();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        apply_reset();
        out_ready = 1'b1;
        in_op = 3'd0; in_a = 8'h0F; in_b = 8'hF0; in_acc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            if (i == 0) begin
                n_cmp++; if (out_data !== 8'h00 || out_zero !== 1'b1 || out_parity !== 1'b0) begin n_bad++; $display("FAIL flags_00 got d=%h zero=%b par=%b exp d=00 zero=1 par=0", out_data, out_zero, out_parity); end
            end
            step();
            n_cmp++; if (s_op_count !== exp_cnt[i]) begin n_bad++; $display("FAIL sat_count beat=%0d got=%0d exp=%0d", i, s_op_count, exp_cnt[i]); end
        end
        n_cmp++; if (op_count !== 16'd5) begin n_bad++; $display("FAIL wide_count got=%0d exp=5", op_count); end
    endtask

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        apply_reset();
        test_reset();
        test_op_sweep();
        test_backpressure();
        test_accumulate();
        test_counter_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
